// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage access unit in front of a word-wide data memory (async read
//   gated by read enable, posedge write). Converts byte/half/word loads and
//   stores into word accesses. Sub-word stores run a two-cycle
//   read-modify-write: the first cycle reads the word and stalls the
//   pipeline; the second cycle writes back the merged word. Load results are
//   sign/zero-extended and registered for the MEM/WB boundary.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   req_valid         request present this cycle
//   req_write         1 store, 0 load
//   req_size          00 byte, 01 half, 10 word, 11 illegal (misaligned)
//   req_unsigned      loads: 1 zero-extend, 0 sign-extend
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   stall             hold the pipeline (request must stay stable)
//   ld_data           registered, extended load result
//   ld_valid          one-cycle pulse, ld_data updated
//   misalign_err      one-cycle registered pulse, access dropped
//   mem_we, mem_re    memory write/read enables
//   mem_addr          memory word index
//   mem_wdata         memory write data
//   mem_rdata         memory read data (combinational)
module load_store_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    output logic                       stall,
    output logic [DATA_WIDTH-1:0]      ld_data,
    output logic                       ld_valid,
    output logic                       misalign_err,
    output logic                       mem_we,
    output logic                       mem_re,
    output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        ld_data_q, ld_data_d;
    logic                         ld_valid_q, ld_valid_d;
    logic                         misalign_q, misalign_d;
    logic [WORD_ADDR_WIDTH-1:0]   rmw_addr_q;
    logic [DATA_WIDTH-1:0]        rmw_wdata_q;
    logic                         misaligned;
    logic [WORD_ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]                   offset;

    // Address bits above the word index and the two lane bits wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:WORD_ADDR_WIDTH+2];

    assign word_idx = req_addr[WORD_ADDR_WIDTH+1:2];
    assign offset   = req_addr[1:0];

    // Replace the addressed byte/half lane of the old word with store data.
    function automatic logic [DATA_WIDTH-1:0] merge_store(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_word;
        if (size == SZ_BYTE) begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
        return r;
    endfunction

    // Select the addressed lane and sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = uns ? {{(DATA_WIDTH-8){1'b0}}, b} : {{(DATA_WIDTH-8){b[7]}}, b};
            SZ_HALF: r = uns ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = offset[0];
            SZ_WORD: misaligned = (offset != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ld_valid_d = 1'b0;
        misalign_d = 1'b0;
        ld_data_d  = extract_load(mem_rdata, offset, req_size, req_unsigned);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else if (!req_write) begin
                        mem_re     = 1'b1;
                        mem_addr   = word_idx;
                        ld_valid_d = 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        mem_we    = 1'b1;
                        mem_addr  = word_idx;
                        mem_wdata = req_wdata;
                    end else begin
                        // Sub-word store: read the word now, write it next cycle.
                        mem_re   = 1'b1;
                        mem_addr = word_idx;
                        stall    = 1'b1;
                        state_d  = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_we    = 1'b1;
                mem_addr  = rmw_addr_q;
                mem_wdata = rmw_wdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_valid_q <= ld_valid_d;
            misalign_q <= misalign_d;
            if (ld_valid_d) begin
                ld_data_q <= ld_data_d;
            end
        end
    end

    // Merge capture carries no reset: it is only consumed from RMW_WR,
    // which is entered solely through this capture.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && state_d == RMW_WR) begin
            rmw_addr_q  <= word_idx;
            rmw_wdata_q <= merge_store(mem_rdata, offset, req_size, req_wdata);
        end
    end

    assign ld_data      = ld_data_q;
    assign ld_valid     = ld_valid_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory
// (async read gated by mem_re, posedge write) and a write-cycle counter.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign_err;
    logic        mem_we;
    logic        mem_re;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem_model [0:1023];
    int          we_cnt = 0;
    int          ncmp = 0;
    int          nfail = 0;
    int          wc;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .misalign_err (misalign_err),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_re ? mem_model[mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem_model[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] d);
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_ld_valid", 32'(ld_valid), 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'h0);
        reset = 1'b0;

        // sw 0xDEADBEEF @0x10, then lw @0x10
        wc = we_cnt;
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        #1;
        chk("sw_we", 32'(mem_we), 32'h1);
        chk("sw_re", 32'(mem_re), 32'h0);
        chk("sw_stall", 32'(stall), 32'h0);
        chk("sw_addr", 32'(mem_addr), 32'h4);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        #1;
        chk("lw_re", 32'(mem_re), 32'h1);
        chk("lw_we", 32'(mem_we), 32'h0);
        chk("lw_stall", 32'(stall), 32'h0);
        tick();
        chk("lw_valid", 32'(ld_valid), 32'h1);
        chk("lw_data", ld_data, 32'hDEADBEEF);
        chk("sw_one_write", 32'(we_cnt - wc), 32'h1);
        idle();
        tick();
        chk("ldv_pulse_low", 32'(ld_valid), 32'h0);
        chk("ld_data_hold", ld_data, 32'hDEADBEEF);

        // sw 0x11223344 @0x20; sb 0xAA @0x21 (upper store bits must be ignored)
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        tick();
        wc = we_cnt;
        set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA);
        #1;
        chk("sb_rd_stall", 32'(stall), 32'h1);
        chk("sb_rd_re", 32'(mem_re), 32'h1);
        chk("sb_rd_we", 32'(mem_we), 32'h0);
        tick();
        chk("sb_wr_stall", 32'(stall), 32'h0);
        chk("sb_wr_we", 32'(mem_we), 32'h1);
        chk("sb_wr_re", 32'(mem_re), 32'h0);
        chk("sb_wr_addr", 32'(mem_addr), 32'h8);
        chk("sb_wr_wdata", mem_wdata, 32'h1122AA44);
        tick();
        chk("sb_one_write", 32'(we_cnt - wc), 32'h1);
        set_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        tick();
        chk("lb_data", ld_data, 32'hFFFFFFAA);
        set_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        tick();
        chk("lbu_data", ld_data, 32'h000000AA);

        // sh 0x8001 @0x22
        set_req(1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h12348001);
        #1;
        chk("sh_rd_stall", 32'(stall), 32'h1);
        tick();
        chk("sh_wr_wdata", mem_wdata, 32'h8001AA44);
        tick();
        set_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        tick();
        chk("lh_data", ld_data, 32'hFFFF8001);
        set_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        tick();
        chk("lhu_data", ld_data, 32'h00008001);

        // misaligned: lw @0x13, lh @0x21, size 11 @0x20
        bad_addr[0] = 32'h13; bad_size[0] = 2'b10;
        bad_addr[1] = 32'h21; bad_size[1] = 2'b01;
        bad_addr[2] = 32'h20; bad_size[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wc = we_cnt;
            set_req(1'b1, 1'b0, bad_size[i], 1'b0, bad_addr[i], 32'h0);
            #1;
            chk($sformatf("mis%0d_mem", i), 32'({mem_we, mem_re}), 32'h0);
            chk($sformatf("mis%0d_stall", i), 32'(stall), 32'h0);
            tick();
            chk($sformatf("mis%0d_err", i), 32'(misalign_err), 32'h1);
            chk($sformatf("mis%0d_ldv", i), 32'(ld_valid), 32'h0);
        end
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555);
        #1;
        chk("mis_sw_we", 32'(mem_we), 32'h0);
        tick();
        chk("mis_sw_err", 32'(misalign_err), 32'h1);
        idle();
        tick();
        chk("mis_pulse_low", 32'(misalign_err), 32'h0);
        chk("mis_no_write", 32'(we_cnt - wc), 32'h0);
        chk("mis_ld_hold", ld_data, 32'h00008001);

        // reset during sb read cycle: no write, memory unchanged
        wc = we_cnt;
        set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h55);
        reset = 1'b1;
        #1;
        chk("rstrmw_stall", 32'(stall), 32'h1);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("rstrmw_we", 32'(mem_we), 32'h0);
        chk("rstrmw_stall2", 32'(stall), 32'h0);
        tick();
        chk("rstrmw_no_write", 32'(we_cnt - wc), 32'h0);
        chk("rstrmw_mem", mem_model[8], 32'h8001AA44);
        chk("rstrmw_ld_data", ld_data, 32'h0);

        // sb, sb, lw to word 0x30 back-to-back
        wc = we_cnt;
        set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h77);
        #1;
        chk("b2b_sb1_stall", 32'(stall), 32'h1);
        tick();
        chk("b2b_sb1_wdata", mem_wdata, 32'h00000077);
        tick();
        set_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h33, 32'h99);
        #1;
        chk("b2b_sb2_stall", 32'(stall), 32'h1);
        tick();
        chk("b2b_sb2_wdata", mem_wdata, 32'h99000077);
        tick();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        #1;
        chk("b2b_lw_stall", 32'(stall), 32'h0);
        tick();
        chk("b2b_ld_valid", 32'(ld_valid), 32'h1);
        chk("b2b_ld_data", ld_data, 32'h99000077);
        chk("b2b_writes", 32'(we_cnt - wc), 32'h2);

        // upper address bits wrap modulo memory depth
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h00001010, 32'h0);
        #1;
        chk("wrap_addr", 32'(mem_addr), 32'h4);
        tick();
        chk("wrap_data", ld_data, 32'hDEADBEEF);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
